// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - program-memory and decoder signals of the control sequencer
interface control_sequencer_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] mem_data;
    logic              mem_ready;
    logic              e;
    logic              m;
    logic [3:0]        state;
    logic [3:0]        inst;
    logic [WORD_W-5:0] operand;

    modport master (
        input  mem_data, mem_ready, e, m,
        output state, inst, operand
    );

    modport slave (
        output mem_data, mem_ready, e, m,
        input  state, inst, operand
    );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/execute timing generator with run/stop, HALT and retire count
module control_sequencer #(
    parameter int         WORD_W  = 8,
    parameter logic [3:0] HALT_OP = 4'hF,
    parameter int         CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    control_sequencer_if.master bus,
    output logic                halted,
    output logic [CNT_W-1:0]    retired
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC1,
        S_EXEC2,
        S_EXEC3,
        S_HALT
    } fsm_t;

    fsm_t              cur_st;
    fsm_t              nxt_st;
    fsm_t              boundary_st;
    logic              load;
    logic              retire;
    logic [3:0]        st_onehot;
    logic [3:0]        inst_q;
    logic [WORD_W-5:0] operand_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_st <= S_IDLE;
        end else begin
            cur_st <= nxt_st;
        end
    end

    assign boundary_st = run ? S_FETCH : S_IDLE;

    always_comb begin
        nxt_st    = cur_st;
        load      = 1'b0;
        retire    = 1'b0;
        st_onehot = 4'b0000;
        case (cur_st)
            S_IDLE: begin
                if (run) nxt_st = S_FETCH;
            end
            S_FETCH: begin
                // Fetch bit only shows once the word is valid, so pc_inc fires once.
                st_onehot = {3'b000, bus.mem_ready};
                if (bus.mem_ready) begin
                    load   = 1'b1;
                    nxt_st = S_EXEC1;
                end
            end
            S_EXEC1: begin
                st_onehot = 4'b0010;
                if (inst_q == HALT_OP) begin
                    nxt_st = S_HALT;
                    retire = 1'b1;
                end else if (bus.e) begin
                    nxt_st = S_EXEC2;
                end else begin
                    nxt_st = boundary_st;
                    retire = 1'b1;
                end
            end
            S_EXEC2: begin
                st_onehot = 4'b0100;
                if (bus.m) begin
                    nxt_st = S_EXEC3;
                end else begin
                    nxt_st = boundary_st;
                    retire = 1'b1;
                end
            end
            S_EXEC3: begin
                st_onehot = 4'b1000;
                nxt_st    = boundary_st;
                retire    = 1'b1;
            end
            S_HALT: begin
                if (!run) nxt_st = S_IDLE;
            end
            default: nxt_st = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q    <= 4'h0;
            operand_q <= '0;
            retired   <= '0;
        end else begin
            if (load) begin
                inst_q    <= bus.mem_data[WORD_W-1 -: 4];
                operand_q <= bus.mem_data[WORD_W-5:0];
            end
            if (retire) retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.state   = st_onehot;
    assign bus.inst    = inst_q;
    assign bus.operand = operand_q;
    assign halted      = (cur_st == S_HALT);
endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer
module tb_control_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        halted;
    logic [15:0] retired;

    control_sequencer_if #(.WORD_W(8)) bus ();

    control_sequencer #(
        .WORD_W (8),
        .HALT_OP(4'hF),
        .CNT_W  (16)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run),
        .bus    (bus),
        .halted (halted),
        .retired(retired)
    );

    always #5 clk = ~clk;

    // Decoder model: opcode 3 needs EXEC2, opcode D needs EXEC2+EXEC3.
    always_comb begin
        bus.e = (bus.inst == 4'h3) || (bus.inst == 4'hD);
        bus.m = (bus.inst == 4'hD);
    end

    typedef struct {
        logic [3:0]  st;
        logic [3:0]  inst;
        logic [3:0]  opnd;
        logic        hlt;
        logic [15:0] ret;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_no   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc_no, got, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] st, input logic [3:0] in, input logic [3:0] op,
                            input logic h, input logic [15:0] r);
        exp_t x;
        x.st   = st;
        x.inst = in;
        x.opnd = op;
        x.hlt  = h;
        x.ret  = r;
        sb.push_back(x);
    endtask

    task automatic sample();
        exp_t x;
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            x = sb.pop_front();
            check("state",   {28'd0, bus.state},   {28'd0, x.st});
            check("inst",    {28'd0, bus.inst},    {28'd0, x.inst});
            check("operand", {28'd0, bus.operand}, {28'd0, x.opnd});
            check("halted",  {31'd0, halted},      {31'd0, x.hlt});
            check("retired", {16'd0, retired},     {16'd0, x.ret});
        end
        cyc_no++;
    endtask

    task automatic cyc(input logic [3:0] st, input logic [3:0] in, input logic [3:0] op,
                       input logic h, input logic [15:0] r);
        push_exp(st, in, op, h, r);
        sample();
        @(negedge clk);
    endtask

    initial begin
        rst_n         = 1'b0;
        run           = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_data  = 8'h00;
        @(negedge clk);
        cyc(4'b0000, 4'h0, 4'h0, 1'b0, 16'd0);
        cyc(4'b0000, 4'h0, 4'h0, 1'b0, 16'd0);

        // 3A: fetch, exec1, exec2
        rst_n         = 1'b1;
        run           = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_data  = 8'h3A;
        cyc(4'b0000, 4'h0, 4'h0, 1'b0, 16'd0);
        cyc(4'b0001, 4'h0, 4'h0, 1'b0, 16'd0);
        cyc(4'b0010, 4'h3, 4'hA, 1'b0, 16'd0);
        cyc(4'b0100, 4'h3, 4'hA, 1'b0, 16'd0);

        // D5: three exec cycles
        bus.mem_data = 8'hD5;
        cyc(4'b0001, 4'h3, 4'hA, 1'b0, 16'd1);
        cyc(4'b0010, 4'hD, 4'h5, 1'b0, 16'd1);
        cyc(4'b0100, 4'hD, 4'h5, 1'b0, 16'd1);
        cyc(4'b1000, 4'hD, 4'h5, 1'b0, 16'd1);

        // 10: single exec cycle
        bus.mem_data = 8'h10;
        cyc(4'b0001, 4'hD, 4'h5, 1'b0, 16'd2);
        cyc(4'b0010, 4'h1, 4'h0, 1'b0, 16'd2);

        // Wait states: word changes under mem_ready=0 must not be latched
        bus.mem_ready = 1'b0;
        bus.mem_data  = 8'hF0;
        cyc(4'b0000, 4'h1, 4'h0, 1'b0, 16'd3);
        cyc(4'b0000, 4'h1, 4'h0, 1'b0, 16'd3);
        cyc(4'b0000, 4'h1, 4'h0, 1'b0, 16'd3);
        bus.mem_ready = 1'b1;
        cyc(4'b0001, 4'h1, 4'h0, 1'b0, 16'd3);

        // F0: HALT, held while run=1
        cyc(4'b0010, 4'hF, 4'h0, 1'b0, 16'd3);
        cyc(4'b0000, 4'hF, 4'h0, 1'b1, 16'd4);
        cyc(4'b0000, 4'hF, 4'h0, 1'b1, 16'd4);
        run = 1'b0;
        cyc(4'b0000, 4'hF, 4'h0, 1'b1, 16'd4);
        cyc(4'b0000, 4'hF, 4'h0, 1'b0, 16'd4);
        run = 1'b1;
        cyc(4'b0000, 4'hF, 4'h0, 1'b0, 16'd4);

        // run dropped in EXEC2 of D5: EXEC3 completes, then IDLE
        bus.mem_data = 8'hD5;
        cyc(4'b0001, 4'hF, 4'h0, 1'b0, 16'd4);
        cyc(4'b0010, 4'hD, 4'h5, 1'b0, 16'd4);
        run = 1'b0;
        cyc(4'b0100, 4'hD, 4'h5, 1'b0, 16'd4);
        cyc(4'b1000, 4'hD, 4'h5, 1'b0, 16'd4);
        cyc(4'b0000, 4'hD, 4'h5, 1'b0, 16'd5);
        cyc(4'b0000, 4'hD, 4'h5, 1'b0, 16'd5);

        // Reset pulse in EXEC1 takes effect before the next edge
        run = 1'b1;
        cyc(4'b0000, 4'hD, 4'h5, 1'b0, 16'd5);
        cyc(4'b0001, 4'hD, 4'h5, 1'b0, 16'd5);
        push_exp(4'b0010, 4'hD, 4'h5, 1'b0, 16'd5);
        sample();
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_state",   {28'd0, bus.state},   32'd0);
        check("async_rst_inst",    {28'd0, bus.inst},    32'd0);
        check("async_rst_operand", {28'd0, bus.operand}, 32'd0);
        check("async_rst_halted",  {31'd0, halted},      32'd0);
        check("async_rst_retired", {16'd0, retired},     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4'b0000, 4'h0, 4'h0, 1'b0, 16'd0);
        cyc(4'b0001, 4'h0, 4'h0, 1'b0, 16'd0);
        cyc(4'b0010, 4'hD, 4'h5, 1'b0, 16'd0);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
